// File: rtl/imem_port_arbiter_if.sv
// Bundle of fetch, loader and byte-memory signals around the instruction memory arbiter.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_flush;
  logic              f_gnt;
  logic              f_rvalid;
  logic [15:0]       f_rdata;
  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [15:0]       l_wdata;
  logic              l_gnt;
  logic              l_done;
  logic [15:0]       l_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  f_req, f_addr, f_flush, l_req, l_we, l_addr, l_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_done, l_rdata,
           mem_addr, mem_en, mem_we, mem_wdata
  );

  modport master (
    output f_req, f_addr, f_flush, l_req, l_we, l_addr, l_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_done, l_rdata,
           mem_addr, mem_en, mem_we, mem_wdata
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Round-robin arbiter sharing one byte-wide instruction memory port between fetch and loader.
// Each 16-bit word access is split into two big-endian byte accesses at addr and addr+1.
module imem_port_arbiter #(
  parameter int ADDR_W = 16
) (
  input  logic clk,
  input  logic rst,
  imem_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_RSP} state_t;

  state_t            state_q, state_d;
  logic              own_l_q, own_l_d;
  logic              rr_l_q, rr_l_d;
  logic              we_q, we_d;
  logic              flush_q, flush_d;
  logic [15:0]       f_rdata_q, f_rdata_d;
  logic [15:0]       l_rdata_q, l_rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       word_q, word_d;

  logic              grant_f, grant_l;
  logic              f_gnt, l_gnt, f_rvalid, l_done;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  always_comb begin
    state_d   = state_q;
    own_l_d   = own_l_q;
    rr_l_d    = rr_l_q;
    we_d      = we_q;
    flush_d   = flush_q;
    f_rdata_d = f_rdata_q;
    l_rdata_d = l_rdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    hi_d      = hi_q;
    word_d    = word_q;
    grant_f   = 1'b0;
    grant_l   = 1'b0;
    f_gnt     = 1'b0;
    l_gnt     = 1'b0;
    f_rvalid  = 1'b0;
    l_done    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    // Reset suppresses every output during the reset cycle, including a grant.
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          grant_f = bus.f_req && (!bus.l_req || rr_l_q);
          grant_l = bus.l_req && !grant_f;
          if (grant_f || grant_l) begin
            f_gnt   = grant_f;
            l_gnt   = grant_l;
            own_l_d = grant_l;
            rr_l_d  = grant_l;
            addr_d  = grant_l ? bus.l_addr : bus.f_addr;
            we_d    = grant_l && bus.l_we;
            wdata_d = bus.l_wdata;
            flush_d = grant_f && bus.f_flush;
            state_d = S_B0;
          end
        end
        S_B0: begin
          mem_en    = 1'b1;
          mem_addr  = addr_q;
          mem_we    = we_q;
          mem_wdata = we_q ? wdata_q[15:8] : 8'h00;
          if (!own_l_q && bus.f_flush) flush_d = 1'b1;
          state_d   = S_B1;
        end
        S_B1: begin
          mem_en    = 1'b1;
          mem_addr  = addr_q + ADDR_W'(1);
          mem_we    = we_q;
          mem_wdata = we_q ? wdata_q[7:0] : 8'h00;
          hi_d      = bus.mem_rdata;
          if (!own_l_q && bus.f_flush) flush_d = 1'b1;
          state_d   = we_q ? S_RSP : S_B2;
        end
        S_B2: begin
          word_d  = {hi_q, bus.mem_rdata};
          if (!own_l_q && bus.f_flush) flush_d = 1'b1;
          state_d = S_RSP;
        end
        S_RSP: begin
          // A flush arriving in the response cycle itself still cancels the fetch.
          f_rvalid = !own_l_q && !(flush_q || bus.f_flush);
          l_done   = own_l_q;
          if (f_rvalid) f_rdata_d = word_q;
          if (l_done && !we_q) l_rdata_d = word_q;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      own_l_q   <= 1'b0;
      rr_l_q    <= 1'b1;
      we_q      <= 1'b0;
      flush_q   <= 1'b0;
      f_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      own_l_q   <= own_l_d;
      rr_l_q    <= rr_l_d;
      we_q      <= we_d;
      flush_q   <= flush_d;
      f_rdata_q <= f_rdata_d;
      l_rdata_q <= l_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    hi_q    <= hi_d;
    word_q  <= word_d;
  end

  assign bus.f_gnt     = f_gnt;
  assign bus.l_gnt     = l_gnt;
  assign bus.f_rvalid  = f_rvalid;
  assign bus.l_done    = l_done;
  assign bus.f_rdata   = rst ? '0 : f_rdata_d;
  assign bus.l_rdata   = rst ? '0 : l_rdata_d;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomized and directed bench for imem_port_arbiter against a transaction-level model
// that predicts grants, byte accesses and responses from the arbitration and timing rules.
module tb_imem_port_arbiter;

  logic clk;
  logic rst;
  imem_port_arbiter_if #(.ADDR_W(16)) bus ();

  imem_port_arbiter #(.ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte memory behind the port; unwritten bytes hold a fixed address-derived pattern.
  logic [7:0] mem [0:65535];
  bit         wr  [0:65535];

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    return wr[a] ? mem[a] : init_byte(a);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr[bus.mem_addr]  <= 1'b1;
    end
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem_rd(bus.mem_addr);
  end

  // Reference memory contents seen by the model.
  logic [7:0] ref_mem [0:65535];
  bit         ref_wr  [0:65535];

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_wr[a] ? ref_mem[a] : init_byte(a);
  endfunction

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model of the arbiter as a transaction: grant at phase 0, bytes at phases 1 and 2,
  // response at phase 3 (write) or 4 (read).
  bit          m_busy = 0;
  int          m_ph   = 0;
  bit          m_own_l, m_we, m_flushed;
  bit          m_rr_l = 1;
  logic [15:0] m_addr, m_wdata;
  logic [15:0] m_frd = 16'h0;
  logic [15:0] m_lrd = 16'h0;

  logic        s_fgnt, s_lgnt, s_fv, s_ld, s_en;
  logic [15:0] s_frd, s_lrd;
  int          fv_cnt = 0;
  int          ld_cnt = 0;
  logic [15:0] alog [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_check();
    logic        e_fg = 0, e_lg = 0, e_fv = 0, e_ld = 0, e_en = 0, e_we = 0;
    logic [15:0] e_addr = 16'h0;
    logic [7:0]  e_wd = 8'h0;
    logic [15:0] word;
    cyc++;
    s_fgnt = bus.f_gnt;  s_lgnt = bus.l_gnt;
    s_fv   = bus.f_rvalid; s_ld = bus.l_done;
    s_en   = bus.mem_en;
    s_frd  = bus.f_rdata; s_lrd = bus.l_rdata;
    if (s_fv === 1'b1) fv_cnt++;
    if (s_ld === 1'b1) ld_cnt++;
    if (s_en === 1'b1) alog.push_back(bus.mem_addr);

    if (rst) begin
      m_busy = 0; m_rr_l = 1; m_frd = 16'h0; m_lrd = 16'h0;
    end else if (!m_busy) begin
      if (bus.f_req && (!bus.l_req || m_rr_l)) begin
        e_fg = 1; m_own_l = 0; m_addr = bus.f_addr; m_we = 0; m_flushed = bus.f_flush;
      end else if (bus.l_req) begin
        e_lg = 1; m_own_l = 1; m_addr = bus.l_addr; m_we = bus.l_we;
        m_wdata = bus.l_wdata; m_flushed = 0;
      end
      if (e_fg || e_lg) begin
        m_busy = 1; m_ph = 0; m_rr_l = e_lg;
      end
    end else begin
      m_ph++;
      if (!m_own_l && bus.f_flush) m_flushed = 1;
      if (m_ph == 1 || m_ph == 2) begin
        e_en   = 1;
        e_we   = m_we;
        e_addr = m_addr + 16'(m_ph - 1);
        if (m_we) begin
          e_wd = (m_ph == 1) ? m_wdata[15:8] : m_wdata[7:0];
          ref_mem[e_addr] = e_wd;
          ref_wr[e_addr]  = 1;
        end
      end
      if (m_ph == (m_we ? 3 : 4)) begin
        m_busy = 0;
        word = {ref_rd(m_addr), ref_rd(m_addr + 16'd1)};
        if (m_own_l) begin
          e_ld = 1;
          if (!m_we) m_lrd = word;
        end else if (!m_flushed) begin
          e_fv = 1;
          m_frd = word;
        end
      end
    end

    chk("f_gnt", 32'(s_fgnt), 32'(e_fg));
    chk("l_gnt", 32'(s_lgnt), 32'(e_lg));
    chk("f_rvalid", 32'(s_fv), 32'(e_fv));
    chk("l_done", 32'(s_ld), 32'(e_ld));
    chk("mem_en", 32'(s_en), 32'(e_en));
    chk("mem_we", 32'(bus.mem_we), 32'(e_we));
    if (e_en) chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
    if (e_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
    chk("f_rdata", 32'(s_frd), 32'(m_frd));
    chk("l_rdata", 32'(s_lrd), 32'(m_lrd));
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  // sel: 0 f_gnt, 1 l_gnt, 2 f_rvalid, 3 l_done; at = cycle of the event or -1.
  task automatic wait_evt(input int sel, input int limit, output int at);
    logic hit;
    at = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      case (sel)
        0:       hit = s_fgnt;
        1:       hit = s_lgnt;
        2:       hit = s_fv;
        default: hit = s_ld;
      endcase
      if (hit === 1'b1) begin
        at = cyc;
        return;
      end
    end
    chk($sformatf("timeout_sel%0d", sel), 32'd0, 32'd1);
  endtask

  task automatic lwrite(input logic [15:0] a, input logic [15:0] d, input string tag);
    int tg, td;
    bus.l_req = 1; bus.l_we = 1; bus.l_addr = a; bus.l_wdata = d;
    wait_evt(1, 20, tg);
    bus.l_req = 0;
    wait_evt(3, 20, td);
    chk({tag, "_wr_lat"}, 32'(td - tg), 32'd3);
  endtask

  task automatic fetch(input logic [15:0] a, input logic [15:0] exp, input string tag);
    int tg, tv;
    bus.f_req = 1; bus.f_addr = a;
    wait_evt(0, 20, tg);
    bus.f_req = 0;
    wait_evt(2, 20, tv);
    chk({tag, "_rd_lat"}, 32'(tv - tg), 32'd4);
    chk({tag, "_rd_data"}, 32'(s_frd), 32'(exp));
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 16'hFFFF;
      1:       return 16'hFFFE;
      default: return 16'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    int tg, td, f0, l0, ng;
    logic [5:0] seq;

    rst = 1;
    bus.f_req = 0; bus.f_addr = 0; bus.f_flush = 0;
    bus.l_req = 0; bus.l_we = 0; bus.l_addr = 0; bus.l_wdata = 0;
    repeat (3) step();
    rst = 0;
    step();
    chk("rst_f_rdata", 32'(s_frd), 32'h0);
    chk("rst_l_rdata", 32'(s_lrd), 32'h0);

    // Word fetch, loader write, fetch-back
    lwrite(16'h0010, 16'h1234, "pre");
    fetch(16'h0010, 16'h1234, "t1");
    lwrite(16'h0200, 16'hBEEF, "t2");
    chk("t2_mem200", 32'(mem_rd(16'h0200)), 32'hBE);
    chk("t2_mem201", 32'(mem_rd(16'h0201)), 32'hEF);
    fetch(16'h0200, 16'hBEEF, "t2f");

    // Address wrap at the top of memory
    lwrite(16'hFFFF, 16'hABCD, "t4");
    chk("t4_memffff", 32'(mem_rd(16'hFFFF)), 32'hAB);
    chk("t4_mem0000", 32'(mem_rd(16'h0000)), 32'hCD);
    alog.delete();
    fetch(16'hFFFF, 16'hABCD, "t4f");
    chk("t4_nacc", 32'(alog.size()), 32'd2);
    if (alog.size() == 2) begin
      chk("t4_addr0", 32'(alog[0]), 32'hFFFF);
      chk("t4_addr1", 32'(alog[1]), 32'h0000);
    end

    // Flush at T+2 of a fetch
    f0 = fv_cnt;
    bus.f_req = 1; bus.f_addr = 16'h0010;
    wait_evt(0, 20, tg);
    bus.f_req = 0;
    step();
    bus.f_flush = 1;
    step();
    bus.f_flush = 0;
    step();
    step();
    chk("t5_no_rvalid", 32'(fv_cnt - f0), 32'd0);
    chk("t5_rdata_held", 32'(s_frd), 32'hABCD);
    bus.f_req = 1; bus.f_addr = 16'h0200;
    step();
    chk("t5_idle_at_T5", 32'(s_fgnt), 32'd1);
    chk("t5_gnt_cycle", 32'(cyc - tg), 32'd5);
    bus.f_req = 0;
    wait_evt(2, 20, td);
    chk("t5_next_data", 32'(s_frd), 32'hBEEF);

    // Loader read, then reset in B1 of another loader read
    bus.l_req = 1; bus.l_we = 0; bus.l_addr = 16'h0200;
    wait_evt(1, 20, tg);
    bus.l_req = 0;
    wait_evt(3, 20, td);
    chk("t6_lrd_lat", 32'(td - tg), 32'd4);
    chk("t6_lrd_data", 32'(s_lrd), 32'hBEEF);
    l0 = ld_cnt;
    bus.l_req = 1; bus.l_addr = 16'h0010;
    wait_evt(1, 20, tg);
    bus.l_req = 0;
    step();
    rst = 1;
    step();
    chk("t6_rst_lrd", 32'(s_lrd), 32'h0);
    chk("t6_rst_frd", 32'(s_frd), 32'h0);
    chk("t6_rst_en", 32'(s_en), 32'h0);
    rst = 0;
    repeat (4) step();
    chk("t6_no_done", 32'(ld_cnt - l0), 32'd0);

    // Contention: both requests held from reset, fetch wins first
    bus.f_req = 1; bus.f_addr = 16'h0200;
    bus.l_req = 1; bus.l_we = 0; bus.l_addr = 16'h0010;
    ng = 0;
    seq = '0;
    for (int i = 0; i < 60 && ng < 6; i++) begin
      step();
      if (i == 0) chk("t3_first_gnt_f", 32'(s_fgnt), 32'd1);
      if (s_fgnt === 1'b1) begin seq[ng] = 1'b0; ng++; end
      else if (s_lgnt === 1'b1) begin seq[ng] = 1'b1; ng++; end
    end
    chk("t3_ngrants", 32'(ng), 32'd6);
    chk("t3_order", 32'(seq), 32'b101010);
    bus.f_req = 0; bus.l_req = 0;
    repeat (6) step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (bus.f_req && s_fgnt) bus.f_req = 0;
      else if (bus.f_req && $urandom_range(0, 19) == 0) bus.f_req = 0;
      if (!bus.f_req && $urandom_range(0, 2) == 0) begin
        bus.f_req = 1; bus.f_addr = rand_addr();
      end
      if (bus.l_req && s_lgnt) bus.l_req = 0;
      else if (bus.l_req && $urandom_range(0, 19) == 0) bus.l_req = 0;
      if (!bus.l_req && $urandom_range(0, 3) == 0) begin
        bus.l_req = 1; bus.l_addr = rand_addr();
        bus.l_we = 1'($urandom_range(0, 1));
        bus.l_wdata = 16'($urandom);
      end
      bus.f_flush = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    bus.f_req = 0; bus.l_req = 0; bus.f_flush = 0; rst = 0;
    repeat (12) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
